// File: rtl/alu_ctrl_pc_if.sv
// Fetch-control and dual-lane ALU signal bundle for alu_ctrl_pc.
// master drives controls and operands; slave returns the PC and the ALU results.
interface alu_ctrl_pc_if;
  logic        stall;
  logic        rollback;
  logic        branchout1;
  logic        branchout2;
  logic [31:0] imm;
  logic [7:0]  pcout;

  logic [1:0]  aluop_1;
  logic [1:0]  aluop_2;
  logic [2:0]  funct3_1;
  logic [2:0]  funct3_2;
  logic [6:0]  funct7_1;
  logic [6:0]  funct7_2;
  logic [4:0]  aluopc_1;
  logic [4:0]  aluopc_2;
  logic [31:0] a_1;
  logic [31:0] b_1;
  logic [31:0] a_2;
  logic [31:0] b_2;
  logic [31:0] result_1;
  logic [31:0] result_2;

  modport master (
    output stall, rollback, branchout1, branchout2, imm,
    output aluop_1, aluop_2, funct3_1, funct3_2, funct7_1, funct7_2,
    output a_1, b_1, a_2, b_2,
    input  pcout, aluopc_1, aluopc_2, result_1, result_2
  );

  modport slave (
    input  stall, rollback, branchout1, branchout2, imm,
    input  aluop_1, aluop_2, funct3_1, funct3_2, funct7_1, funct7_2,
    input  a_1, b_1, a_2, b_2,
    output pcout, aluopc_1, aluopc_2, result_1, result_2
  );
endinterface

// File: rtl/alu_ctrl_pc.sv
// Dual-issue fetch PC (8-bit, two instructions per fetch) plus two independent
// combinational ALU-control/ALU lanes.
module alu_ctrl_pc (
  input logic         clk,
  input logic         reset,
  alu_ctrl_pc_if.slave bus
);

  localparam logic [4:0] OpAdd  = 5'd0;
  localparam logic [4:0] OpSub  = 5'd1;
  localparam logic [4:0] OpSll  = 5'd2;
  localparam logic [4:0] OpSlt  = 5'd3;
  localparam logic [4:0] OpSltu = 5'd4;
  localparam logic [4:0] OpXor  = 5'd5;
  localparam logic [4:0] OpSrl  = 5'd6;
  localparam logic [4:0] OpSra  = 5'd7;
  localparam logic [4:0] OpOr   = 5'd8;
  localparam logic [4:0] OpAnd  = 5'd9;

  localparam logic [6:0] Funct7Alt = 7'b0100000;

  // ---------------------------------------------------------------------------
  // PC: priority reset > stall > branch > rollback > normal, all modulo 256
  logic [7:0] pc_q, pc_d;
  logic       unused_imm;

  assign unused_imm = ^bus.imm[31:8];

  always_comb begin
    pc_d = pc_q + 8'd8;
    if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.branchout1 || bus.branchout2) begin
      pc_d = pc_q + bus.imm[7:0];
    end else if (bus.rollback) begin
      pc_d = pc_q + 8'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 8'h00;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pcout = pc_q;

  // ---------------------------------------------------------------------------
  // ALU control decode, shared by both lanes
  function automatic logic [4:0] alu_decode(input logic [1:0] aluop,
                                            input logic [2:0] funct3,
                                            input logic [6:0] funct7);
    logic       alt;
    logic [4:0] opc;
    alt = (funct7 == Funct7Alt);
    opc = OpAdd;
    unique case (aluop)
      2'b00: opc = OpAdd;
      2'b01: opc = OpSub;
      default: begin
        // I-type (aluop 11) has no SUB; funct7 still selects SRA/SRL
        unique case (funct3)
          3'b000:  opc = (alt && aluop == 2'b10) ? OpSub : OpAdd;
          3'b001:  opc = OpSll;
          3'b010:  opc = OpSlt;
          3'b011:  opc = OpSltu;
          3'b100:  opc = OpXor;
          3'b101:  opc = alt ? OpSra : OpSrl;
          3'b110:  opc = OpOr;
          default: opc = OpAnd;
        endcase
      end
    endcase
    return opc;
  endfunction

  function automatic logic [31:0] alu_eval(input logic [4:0]  opc,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [4:0]  shamt;
    logic [31:0] res;
    shamt = b[4:0];
    case (opc)
      OpAdd:   res = a + b;
      OpSub:   res = a - b;
      OpSll:   res = a << shamt;
      OpSlt:   res = {31'b0, $signed(a) < $signed(b)};
      OpSltu:  res = {31'b0, a < b};
      OpXor:   res = a ^ b;
      OpSrl:   res = a >> shamt;
      OpSra:   res = $unsigned($signed(a) >>> shamt);
      OpOr:    res = a | b;
      OpAnd:   res = a & b;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

  always_comb begin
    bus.aluopc_1 = alu_decode(bus.aluop_1, bus.funct3_1, bus.funct7_1);
    bus.aluopc_2 = alu_decode(bus.aluop_2, bus.funct3_2, bus.funct7_2);
    bus.result_1 = alu_eval(bus.aluopc_1, bus.a_1, bus.b_1);
    bus.result_2 = alu_eval(bus.aluopc_2, bus.a_2, bus.b_2);
  end

endmodule

// File: tb/tb_alu_ctrl_pc.sv
// Directed self-checking bench for alu_ctrl_pc: PC sequencing/priority and
// both ALU lanes against hand-computed vectors.
module tb_alu_ctrl_pc;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  alu_ctrl_pc_if bus ();

  alu_ctrl_pc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  opc;
    logic [31:0] res;
  } vec_t;

  localparam int NumVec = 19;
  vec_t vecs [NumVec];

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    bus.stall      = 1'b0;
    bus.rollback   = 1'b0;
    bus.branchout1 = 1'b0;
    bus.branchout2 = 1'b0;
    bus.imm        = 32'h0;
  endtask

  task automatic do_reset();
    clear_ctrl();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_ctrl();
    bus.stall      = 1'b1;
    bus.branchout1 = 1'b1;
    bus.rollback   = 1'b1;
    bus.imm        = 32'h44;
    reset          = 1'b1;
    step();
    n_tests++;
    if (bus.pcout !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_override: pcout=%h expected=00", bus.pcout);
    end
    reset = 1'b0;
    clear_ctrl();
  endtask

  task automatic test_free_run();
    logic [7:0] exp;
    do_reset();
    n_tests++;
    if (bus.pcout !== 8'h00) begin
      n_fail++;
      $display("FAIL free_run_start: pcout=%h expected=00", bus.pcout);
    end
    exp = 8'h00;
    for (int i = 1; i <= 32; i++) begin
      step();
      exp = exp + 8'h08;
      if (i <= 3 || i >= 31) begin
        n_tests++;
        if (bus.pcout !== exp) begin
          n_fail++;
          $display("FAIL free_run_%0d: pcout=%h expected=%h", i, bus.pcout, exp);
        end
      end
    end
  endtask

  task automatic test_stall_branch();
    do_reset();
    step();
    step();
    n_tests++;
    if (bus.pcout !== 8'h10) begin
      n_fail++;
      $display("FAIL stall_setup: pcout=%h expected=10", bus.pcout);
    end
    bus.stall      = 1'b1;
    bus.branchout1 = 1'b1;
    bus.imm        = 32'h20;
    step();
    n_tests++;
    if (bus.pcout !== 8'h10) begin
      n_fail++;
      $display("FAIL stall_hold: pcout=%h expected=10", bus.pcout);
    end
    bus.stall = 1'b0;
    step();
    n_tests++;
    if (bus.pcout !== 8'h30) begin
      n_fail++;
      $display("FAIL branch_after_stall: pcout=%h expected=30", bus.pcout);
    end
    clear_ctrl();
  endtask

  task automatic test_rollback();
    do_reset();
    repeat (4) step();
    bus.rollback = 1'b1;
    step();
    n_tests++;
    if (bus.pcout !== 8'h24) begin
      n_fail++;
      $display("FAIL rollback: pcout=%h expected=24", bus.pcout);
    end
    do_reset();
    repeat (4) step();
    bus.rollback   = 1'b1;
    bus.branchout2 = 1'b1;
    bus.imm        = 32'hFFFF_FFF0;
    step();
    n_tests++;
    if (bus.pcout !== 8'h10) begin
      n_fail++;
      $display("FAIL branch2_over_rollback: pcout=%h expected=10", bus.pcout);
    end
    // Wrap on branch: 0x10 + 0xF8 = 0x108 -> 0x08
    bus.rollback   = 1'b0;
    bus.branchout2 = 1'b0;
    bus.branchout1 = 1'b1;
    bus.imm        = 32'h0000_00F8;
    step();
    n_tests++;
    if (bus.pcout !== 8'h08) begin
      n_fail++;
      $display("FAIL branch_wrap: pcout=%h expected=08", bus.pcout);
    end
    clear_ctrl();
    step();
    n_tests++;
    if (bus.pcout !== 8'h10) begin
      n_fail++;
      $display("FAIL resume_normal: pcout=%h expected=10", bus.pcout);
    end
  endtask

  task automatic test_alu_lanes();
    vecs[0]  = '{2'b10, 3'b000, 7'h20, 32'd5,          32'd7,          5'd1, 32'hFFFF_FFFE};
    vecs[1]  = '{2'b11, 3'b000, 7'h20, 32'd5,          32'd7,          5'd0, 32'd12};
    vecs[2]  = '{2'b10, 3'b101, 7'h20, 32'h8000_0000, 32'h24,         5'd7, 32'hF800_0000};
    vecs[3]  = '{2'b10, 3'b101, 7'h00, 32'h8000_0000, 32'h24,         5'd6, 32'h0800_0000};
    vecs[4]  = '{2'b10, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1,          5'd3, 32'd1};
    vecs[5]  = '{2'b10, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1,          5'd4, 32'd0};
    vecs[6]  = '{2'b00, 3'b111, 7'h20, 32'hFFFF_FFFF, 32'd1,          5'd0, 32'd0};
    vecs[7]  = '{2'b01, 3'b110, 7'h00, 32'h10,        32'd3,          5'd1, 32'h0D};
    vecs[8]  = '{2'b10, 3'b001, 7'h00, 32'd1,         32'h21,         5'd2, 32'd2};
    vecs[9]  = '{2'b10, 3'b100, 7'h00, 32'h0F0F,      32'h00FF,       5'd5, 32'h0FF0};
    vecs[10] = '{2'b10, 3'b110, 7'h00, 32'h0F00,      32'h00F0,       5'd8, 32'h0FF0};
    vecs[11] = '{2'b10, 3'b111, 7'h00, 32'h0F0F,      32'h00FF,       5'd9, 32'h000F};
    vecs[12] = '{2'b10, 3'b000, 7'h01, 32'd3,         32'd4,          5'd0, 32'd7};
    vecs[13] = '{2'b11, 3'b101, 7'h20, 32'hF000_0000, 32'd8,          5'd7, 32'hFFF0_0000};
    vecs[14] = '{2'b11, 3'b101, 7'h00, 32'hF000_0000, 32'd8,          5'd6, 32'h00F0_0000};
    vecs[15] = '{2'b10, 3'b101, 7'h01, 32'hF000_0000, 32'd4,          5'd6, 32'h0F00_0000};
    vecs[16] = '{2'b10, 3'b010, 7'h00, 32'd1,         32'hFFFF_FFFF,  5'd3, 32'd0};
    vecs[17] = '{2'b10, 3'b011, 7'h00, 32'd1,         32'hFFFF_FFFF,  5'd4, 32'd1};
    vecs[18] = '{2'b11, 3'b010, 7'h00, 32'h8000_0000, 32'd0,          5'd3, 32'd1};
    // Lane 2 runs a different vector each time to expose any cross-lane coupling
    for (int i = 0; i < NumVec; i++) begin
      int j;
      j = (i + 7) % NumVec;
      bus.aluop_1  = vecs[i].aluop;
      bus.funct3_1 = vecs[i].f3;
      bus.funct7_1 = vecs[i].f7;
      bus.a_1      = vecs[i].a;
      bus.b_1      = vecs[i].b;
      bus.aluop_2  = vecs[j].aluop;
      bus.funct3_2 = vecs[j].f3;
      bus.funct7_2 = vecs[j].f7;
      bus.a_2      = vecs[j].a;
      bus.b_2      = vecs[j].b;
      #2;
      n_tests++;
      if (bus.aluopc_1 !== vecs[i].opc || bus.result_1 !== vecs[i].res) begin
        n_fail++;
        $display("FAIL lane1_vec%0d: aluopc=%0d result=%h expected aluopc=%0d result=%h",
                 i, bus.aluopc_1, bus.result_1, vecs[i].opc, vecs[i].res);
      end
      n_tests++;
      if (bus.aluopc_2 !== vecs[j].opc || bus.result_2 !== vecs[j].res) begin
        n_fail++;
        $display("FAIL lane2_vec%0d: aluopc=%0d result=%h expected aluopc=%0d result=%h",
                 j, bus.aluopc_2, bus.result_2, vecs[j].opc, vecs[j].res);
      end
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b0;
    bus.aluop_1  = 2'b00;
    bus.aluop_2  = 2'b00;
    bus.funct3_1 = 3'b000;
    bus.funct3_2 = 3'b000;
    bus.funct7_1 = 7'h00;
    bus.funct7_2 = 7'h00;
    bus.a_1      = 32'h0;
    bus.b_1      = 32'h0;
    bus.a_2      = 32'h0;
    bus.b_2      = 32'h0;
    clear_ctrl();
    #2;
    test_reset();
    test_free_run();
    test_stall_branch();
    test_rollback();
    test_alu_lanes();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
